// File: rtl/bram_fifo_ctrl_if.sv
// Stream and BRAM-port bundle for bram_fifo_ctrl.
// slave = the FIFO controller; master = producer, consumer and attached BRAM.
interface bram_fifo_ctrl_if #(
  parameter int DATA = 8,
  parameter int ADDR = 10
);
  logic            w_valid;
  logic [DATA-1:0] w_data;
  logic            w_ready;
  logic            r_valid;
  logic [DATA-1:0] r_data;
  logic            r_ready;
  logic            ram_a_we;
  logic [ADDR-1:0] ram_a_addr;
  logic [DATA-1:0] ram_a_write;
  logic [ADDR-1:0] ram_b_addr;
  logic [DATA-1:0] ram_b_read;

  modport slave (
    input  w_valid, w_data, r_ready, ram_b_read,
    output w_ready, r_valid, r_data, ram_a_we, ram_a_addr, ram_a_write, ram_b_addr
  );

  modport master (
    output w_valid, w_data, r_ready, ram_b_read,
    input  w_ready, r_valid, r_data, ram_a_we, ram_a_addr, ram_a_write, ram_b_addr
  );
endinterface

// File: rtl/bram_fifo_ctrl.sv
// Valid/ready stream FIFO around a 1-cycle-latency dual-port BRAM with a 2-entry output skid.
// Optional BRAM_FIFO_LEVEL_EN adds the level and almost_full outputs.
module bram_fifo_ctrl #(
  parameter int DATA  = 8,
  parameter int ADDR  = 10
`ifdef BRAM_FIFO_LEVEL_EN
  , parameter int AFULL = 2**ADDR - 4
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  bram_fifo_ctrl_if.slave bus
`ifdef BRAM_FIFO_LEVEL_EN
  , output logic [ADDR:0] level
  , output logic          almost_full
`endif
);

  localparam logic [ADDR:0]   DEPTH   = {1'b1, {ADDR{1'b0}}};
  localparam logic [ADDR-1:0] PTR_ONE = ADDR'(1);
  localparam logic [ADDR:0]   CNT_ONE = (ADDR+1)'(1);

  // mem_cnt: words written but not yet fetched; level: every word held anywhere.
  typedef struct packed {
    logic [ADDR-1:0]      wr_ptr;
    logic [ADDR-1:0]      rd_ptr;
    logic [ADDR-1:0]      b_addr;
    logic [ADDR:0]        mem_cnt;
    logic [ADDR:0]        level;
    logic                 full;
    logic                 fetch_pend;
    logic [1:0]           skid_cnt;
    logic                 skid_head;
    logic [1:0][DATA-1:0] skid;
  } state_t;

  state_t st_q, st_d;
  logic   push, pop, fetch;
  logic   skid_slot;

  assign push = bus.w_valid & ~st_q.full & ~flush;
  assign pop  = bus.r_valid & bus.r_ready;

  // Fetch only while the skid plus the in-flight word leaves room after this cycle's pop.
  assign fetch = ~flush & (st_q.mem_cnt != '0) &
                 (({1'b0, st_q.skid_cnt} + {2'b00, st_q.fetch_pend}) < (3'd2 + {2'b00, pop}));

  assign skid_slot = st_q.skid_head ^ st_q.skid_cnt[0];

  assign bus.w_ready     = ~st_q.full;
  assign bus.r_valid     = (st_q.skid_cnt != 2'd0);
  assign bus.r_data      = st_q.skid[st_q.skid_head];
  assign bus.ram_a_we    = push;
  assign bus.ram_a_addr  = st_q.wr_ptr;
  assign bus.ram_a_write = bus.w_data;
  assign bus.ram_b_addr  = fetch ? st_q.rd_ptr : st_q.b_addr;

  always_comb begin
    // NOTE: start from the held state so every field has a value on every path (no latches).
    st_d = st_q;
    if (flush) begin
      st_d = '0;
    end else begin
      if (push)  st_d.wr_ptr = st_q.wr_ptr + PTR_ONE;
      if (fetch) st_d.rd_ptr = st_q.rd_ptr + PTR_ONE;
      st_d.b_addr     = bus.ram_b_addr;
      st_d.fetch_pend = fetch;

      case ({push, fetch})
        2'b10:   st_d.mem_cnt = st_q.mem_cnt + CNT_ONE;
        2'b01:   st_d.mem_cnt = st_q.mem_cnt - CNT_ONE;
        default: st_d.mem_cnt = st_q.mem_cnt;
      endcase

      case ({push, pop})
        2'b10:   st_d.level = st_q.level + CNT_ONE;
        2'b01:   st_d.level = st_q.level - CNT_ONE;
        default: st_d.level = st_q.level;
      endcase
      st_d.full = (st_d.level == DEPTH);

      if (st_q.fetch_pend) st_d.skid[skid_slot] = bus.ram_b_read;
      if (pop) st_d.skid_head = ~st_q.skid_head;
      case ({st_q.fetch_pend, pop})
        2'b10:   st_d.skid_cnt = st_q.skid_cnt + 2'd1;
        2'b01:   st_d.skid_cnt = st_q.skid_cnt - 2'd1;
        default: st_d.skid_cnt = st_q.skid_cnt;
      endcase
    end
  end

  // NOTE: the two skid words are reset so r_data reads 0; the BRAM array itself never is.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) st_q <= '0;
    else       st_q <= st_d;
  end

`ifdef BRAM_FIFO_LEVEL_EN
  localparam logic [ADDR:0] AFULL_W = (ADDR+1)'(AFULL);

  logic almost_full_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) almost_full_q <= 1'b0;
    else       almost_full_q <= (st_d.level >= AFULL_W);
  end

  assign level       = st_q.level;
  assign almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Scoreboard bench for bram_fifo_ctrl with a behavioural 1-cycle-latency BRAM.
// Build with BRAM_FIFO_LEVEL_EN defined to also cover level/almost_full.
module tb_bram_fifo_ctrl;
  localparam int DATA  = 8;
  localparam int ADDR  = 10;
  localparam int DEPTH = 1 << ADDR;
  localparam int AFULL = DEPTH - 4;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  bram_fifo_ctrl_if #(.DATA(DATA), .ADDR(ADDR)) bus ();

`ifdef BRAM_FIFO_LEVEL_EN
  logic [ADDR:0] level;
  logic          almost_full;
`endif

  bram_fifo_ctrl #(
    .DATA(DATA),
    .ADDR(ADDR)
`ifdef BRAM_FIFO_LEVEL_EN
    , .AFULL(AFULL)
`endif
  ) dut (
    .clk  (clk),
    .reset(reset),
    .flush(flush),
    .bus  (bus)
`ifdef BRAM_FIFO_LEVEL_EN
    , .level      (level)
    , .almost_full(almost_full)
`endif
  );

  always #5 clk = ~clk;

  // BRAM: port A write, port B registered read (data one cycle after the address edge).
  logic [DATA-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_a_we) mem[bus.ram_a_addr] <= bus.ram_a_write;
    bus.ram_b_read <= mem[bus.ram_b_addr];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mlevel = 0;
  int first_pop = -1;
  int last_pop = -1;
  logic [DATA-1:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    bus.r_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.r_valid) && n < budget) begin
      tick();
      n++;
    end
    check("drain_done", 32'((exp_q.size() == 0) && !bus.r_valid), 1);
  endtask

  // Monitor: mid-cycle sampling of this cycle's handshakes against the occupancy model.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        mlevel = 0;
      end else begin
        automatic logic acc = bus.w_valid && (mlevel != DEPTH);
`ifdef BRAM_FIFO_LEVEL_EN
        check("level", 32'(level), mlevel);
        check("almost_full", 32'(almost_full), 32'(mlevel >= AFULL));
`endif
        if (flush) begin
          exp_q.delete();
          mlevel = 0;
        end else begin
          if (bus.w_valid) check("w_ready", 32'(bus.w_ready), 32'(mlevel != DEPTH));
          if (bus.r_valid && bus.r_ready) begin
            if (exp_q.size() == 0) check("pop_unexpected", 1, 0);
            else check("r_data", 32'(bus.r_data), 32'(exp_q.pop_front()));
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
            mlevel--;
          end
          if (acc) begin
            exp_q.push_back(bus.w_data);
            mlevel++;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int start;
    reset = 1'b1;
    flush = 1'b0;
    bus.w_valid = 1'b0;
    bus.w_data = '0;
    bus.r_ready = 1'b0;
    repeat (2) tick();
    check("rst_w_ready", 32'(bus.w_ready), 1);
    check("rst_r_valid", 32'(bus.r_valid), 0);
    check("rst_r_data", 32'(bus.r_data), 0);
    check("rst_a_we", 32'(bus.ram_a_we), 0);
`ifdef BRAM_FIFO_LEVEL_EN
    check("rst_level", 32'(level), 0);
    check("rst_afull", 32'(almost_full), 0);
`endif
    reset = 1'b0;

    // Single word: write port pass-through, then 2-cycle read latency.
    bus.w_valid = 1'b1;
    bus.w_data = 8'hA5;
    #1;
    check("t1_a_we", 32'(bus.ram_a_we), 1);
    check("t1_a_addr", 32'(bus.ram_a_addr), 0);
    check("t1_a_write", 32'(bus.ram_a_write), 32'h A5);
    tick();
    bus.w_valid = 1'b0;
    check("t1_rv_e1", 32'(bus.r_valid), 0);
    tick();
    check("t1_rv_e2", 32'(bus.r_valid), 0);
    tick();
    check("t1_rv_e3", 32'(bus.r_valid), 1);
    check("t1_rdata", 32'(bus.r_data), 32'h A5);
    bus.r_ready = 1'b1;
    tick();
    check("t1_rv_after_pop", 32'(bus.r_valid), 0);

    // Streaming 0x00..0xFF with the consumer always ready: no bubbles.
    first_pop = -1;
    last_pop = -1;
    start = cyc;
    for (int i = 0; i < 256; i++) begin
      bus.w_valid = 1'b1;
      bus.w_data = 8'(i);
      tick();
    end
    bus.w_valid = 1'b0;
    drain(50);
    check("t2_startup", 32'(first_pop - start), 3);
    check("t2_gapless", 32'(last_pop - first_pop), 255);

    // Fill to exactly DEPTH words; extra writes are refused.
    bus.r_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.w_valid = 1'b1;
      bus.w_data = 8'(i + (i >> 8));
      tick();
`ifdef BRAM_FIFO_LEVEL_EN
      if (i + 1 == AFULL - 1) check("t3_afull_below", 32'(almost_full), 0);
      if (i + 1 == AFULL)     check("t3_afull_at", 32'(almost_full), 1);
`endif
    end
    check("t3_full_ready", 32'(bus.w_ready), 0);
    bus.w_data = 8'hEE;
    repeat (3) tick();
    check("t3_still_full", 32'(bus.w_ready), 0);
`ifdef BRAM_FIFO_LEVEL_EN
    check("t3_level", 32'(level), DEPTH);
`endif

    // Full with push and pop together: pop wins, push lands one cycle later.
    bus.r_ready = 1'b1;
    #1;
    check("t4_ready_when_full", 32'(bus.w_ready), 0);
    tick();
    check("t4_ready_after_pop", 32'(bus.w_ready), 1);
    tick();
    for (int j = 0; j < 40; j++) begin
      bus.w_data = 8'(8'h40 + j);
      tick();
    end
    bus.w_valid = 1'b0;
    drain(1200);

    // Flush with 5 words held and a fetch in flight.
    bus.r_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.w_valid = 1'b1;
      bus.w_data = 8'(8'h10 + i);
      tick();
    end
    bus.w_valid = 1'b0;
    repeat (4) tick();
    bus.r_ready = 1'b1;
    tick();
    bus.r_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t5_rv_flushed", 32'(bus.r_valid), 0);
    check("t5_wr_flushed", 32'(bus.w_ready), 1);
`ifdef BRAM_FIFO_LEVEL_EN
    check("t5_level_flushed", 32'(level), 0);
`endif
    repeat (2) tick();
    check("t5_inflight_dropped", 32'(bus.r_valid), 0);
    bus.w_valid = 1'b1;
    bus.w_data = 8'h3C;
    tick();
    bus.w_valid = 1'b0;
    repeat (2) tick();
    check("t5_next_valid", 32'(bus.r_valid), 1);
    check("t5_next_word", 32'(bus.r_data), 32'h3C);
    drain(10);

    // Reset mid-operation clears immediately.
    bus.r_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.w_valid = 1'b1;
      bus.w_data = 8'(8'h50 + i);
      tick();
    end
    bus.w_valid = 1'b0;
    repeat (2) tick();
    #2 reset = 1'b1;
    #1;
    check("t6_rv_reset", 32'(bus.r_valid), 0);
    check("t6_rdata_reset", 32'(bus.r_data), 0);
    check("t6_wr_reset", 32'(bus.w_ready), 1);
    @(posedge clk);
    #1 reset = 1'b0;
    bus.w_valid = 1'b1;
    bus.w_data = 8'h99;
    tick();
    bus.w_valid = 1'b0;
    drain(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
